ra_sim_engine: RTL and testbench
================================

RA_SIM_ENGINE -- requirements
Module: ra_sim_engine

Interface
REQ-001 Parameters SHALL be: RULES, default 8, number of network elements; LOG_RULES, default 3, rule index width (2^LOG_RULES >= RULES); STEP_W, default 16, step counter width.
REQ-002 clk  in  1  sole clock; all state on rising edge.
REQ-003 rst  in  1  asynchronous, active-low reset.
REQ-004 start  in  1  begin run when IDLE; ignored otherwise.
REQ-005 abort  in  1  return to IDLE from any state.
REQ-006 mode  in  2  update scheme: 0 random-async, 1 round-robin, 2 synchronous, 3 reserved (treated as 0).
REQ-007 seed  in  64  LFSR seed, sampled on accepted start.
REQ-008 init_state  in  RULES  network state loaded on accepted start.
REQ-009 max_steps  in  STEP_W  step limit, sampled on accepted start; 0 means 2^STEP_W-1.
REQ-010 ld_inhibitor  in  1  set inhibitor bit sel_inhibitor.
REQ-011 sel_inhibitor  in  LOG_RULES  inhibitor bit index.
REQ-012 clr_inhibitor  in  1  clear whole inhibitor mask.
REQ-013 logic_output  in  RULES  next-state vector from external combinational network logic.
REQ-014 network_state  out  RULES  current state AND NOT inhibitor mask.
REQ-015 busy  out  1  high in RUN.
REQ-016 done  out  1  high in DONE, held until next accepted start or abort.
REQ-017 steady_state  out  1  valid with done; 1 = fixed point reached, 0 = step limit hit.
REQ-018 step_count  out  STEP_W  valid updates performed this run.

Function
REQ-019 FSM SHALL have states IDLE, RUN, DONE; IDLE->RUN on start; RUN->DONE on steady or limit; DONE->RUN on start; any->IDLE on abort (abort wins over start in the same cycle).
REQ-020 Accepted start SHALL load state=init_state, lfsr=seed (seed 0 replaced by 1), step_count=0, updated vector=0, rr index=0.
REQ-021 LFSR SHALL advance every RUN cycle: s <= {s[62:0], s[63]^s[62]^s[60]^s[59]}.
REQ-022 Mode 0 rule index SHALL be s[LOG_RULES-1:0]; index >= RULES is invalid: cycle consumed, no update, step_count unchanged.
REQ-023 Mode 1 rule index SHALL be rr index, incrementing by 1 per step, wrapping RULES-1 -> 0.
REQ-024 Valid step on rule r: state[r] <= logic_output[r] & ~inhib[r]; step_count += 1.
REQ-025 If state[r] changes, updated SHALL become one-hot(r); otherwise updated[r] <= 1.
REQ-026 Modes 0/1 steady SHALL be updated == all-ones after a step; DONE entered next cycle with steady_state=1.
REQ-027 Mode 2 SHALL update all bits per cycle: state <= logic_output & ~inhib; steady when that value equals current state (state unchanged, step still counted).
REQ-028 When step_count reaches limit without steady, SHALL enter DONE with steady_state=0; steady on the same step takes priority.
REQ-029 Inhibitor load/clear SHALL be honoured in every state and take effect the following cycle; clear wins over simultaneous load.
REQ-030 In IDLE/DONE, state, step_count, steady_state SHALL hold.

Reset
REQ-031 rst low SHALL force IDLE, state=0, inhibitor=0, updated=0, lfsr=1, step_count=0, busy=0, done=0, steady_state=0, asynchronously, including mid-run.

Configuration
REQ-032 Macro RA_SYNC_MODE_EN: defined -> mode 2 as REQ-027; undefined -> synchronous datapath omitted and mode 2 treated as mode 0.

Verification
REQ-033 RULES=4, logic_output=network_state, mode 1, init 4'b1010 -> done after 4 steps, steady_state=1, step_count=4, network_state=4'b1010.
REQ-034 RULES=4, logic_output=~network_state, mode 0, max_steps=20 -> done, steady_state=0, step_count=20.
REQ-035 RULES=5, LOG_RULES=3, mode 0, identity logic, seed 64'h1 -> invalid indices 5..7 never counted; steady_state=1, all 5 bits visited.
REQ-036 Inhibit bit 1, init 4'b1111, identity, mode 1 -> network_state=4'b1101 next cycle; done, steady_state=1 in 4 steps.
REQ-037 rst low mid-run at step 7 -> all outputs 0 immediately; start after release runs cleanly from step_count=0.
REQ-038 With RA_SYNC_MODE_EN, mode 2, identity, init 4'b0110 -> done after 1 step, steady_state=1; without macro -> mode 0 behaviour.

Source files
------------

// File: rtl/ra_sim_engine.sv
`default_nettype none
// ============================================================================
// ra_sim_engine : Boolean-network simulation engine; optional RA_SYNC_MODE_EN
//                 adds the synchronous (mode 2) update datapath.
// Revision      : 1.0
// ============================================================================
module ra_sim_engine #(
    parameter int RULES     = 8,
    parameter int LOG_RULES = 3,
    parameter int STEP_W    = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 abort,
    input  logic [1:0]           mode,
    input  logic [63:0]          seed,
    input  logic [RULES-1:0]     init_state,
    input  logic [STEP_W-1:0]    max_steps,
    input  logic                 ld_inhibitor,
    input  logic [LOG_RULES-1:0] sel_inhibitor,
    input  logic                 clr_inhibitor,
    input  logic [RULES-1:0]     logic_output,
    output logic [RULES-1:0]     network_state,
    output logic                 busy,
    output logic                 done,
    output logic                 steady_state,
    output logic [STEP_W-1:0]    step_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } fsm_e;

    localparam logic [1:0] MODE_RR = 2'd1;

    fsm_e                 fsm_q;
    logic [RULES-1:0]     state_q, state_d;
    logic [RULES-1:0]     inhib_q;
    logic [RULES-1:0]     updated_q, updated_d;
    logic [RULES-1:0]     vis_state, onehot;
    logic [63:0]          lfsr_q, lfsr_d;
    logic [STEP_W-1:0]    step_q, step_d, limit_q;
    logic [LOG_RULES-1:0] rr_q, rr_d, idx;
    logic                 idx_valid, stepped, steady_hit, limit_hit, new_bit;
    logic                 busy_q, done_q, steady_q;

    assign vis_state     = state_q & ~inhib_q;
    assign network_state = vis_state;
    assign busy          = busy_q;
    assign done          = done_q;
    assign steady_state  = steady_q;
    assign step_count    = step_q;

    assign lfsr_d    = {lfsr_q[62:0], lfsr_q[63] ^ lfsr_q[62] ^ lfsr_q[60] ^ lfsr_q[59]};
    assign idx       = (mode == MODE_RR) ? rr_q : lfsr_q[LOG_RULES-1:0];
    assign idx_valid = (32'(idx) < 32'(RULES));
    assign rr_d      = (32'(rr_q) >= 32'(RULES - 1)) ? '0 : rr_q + LOG_RULES'(1);

`ifdef RA_SYNC_MODE_EN
    logic [RULES-1:0] sync_next;
    assign sync_next = logic_output & ~inhib_q;
`endif

    // Change detection works on the visible (inhibited) state, so a masked bit
    // being forced low never restarts the fixed-point sweep.
    always_comb begin
        state_d    = state_q;
        updated_d  = updated_q;
        step_d     = step_q;
        onehot     = '0;
        new_bit    = 1'b0;
        stepped    = 1'b0;
        steady_hit = 1'b0;
`ifdef RA_SYNC_MODE_EN
        if (mode == 2'd2) begin
            state_d    = sync_next;
            step_d     = step_q + STEP_W'(1);
            stepped    = 1'b1;
            steady_hit = (sync_next == vis_state);
        end else
`endif
        if (idx_valid) begin
            onehot[idx]    = 1'b1;
            new_bit        = logic_output[idx] & ~inhib_q[idx];
            state_d[idx]   = new_bit;
            step_d         = step_q + STEP_W'(1);
            stepped        = 1'b1;
            updated_d      = (new_bit != vis_state[idx]) ? onehot : (updated_q | onehot);
            steady_hit     = (updated_d == '1);
        end
    end

    assign limit_hit = stepped && (step_d == limit_q);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fsm_q     <= IDLE;
            state_q   <= '0;
            inhib_q   <= '0;
            updated_q <= '0;
            lfsr_q    <= 64'd1;
            step_q    <= '0;
            limit_q   <= '0;
            rr_q      <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            steady_q  <= 1'b0;
        end else begin
            if (clr_inhibitor) begin
                inhib_q <= '0;
            end else if (ld_inhibitor && (32'(sel_inhibitor) < 32'(RULES))) begin
                inhib_q[sel_inhibitor] <= 1'b1;
            end

            if (abort) begin
                fsm_q  <= IDLE;
                busy_q <= 1'b0;
                done_q <= 1'b0;
            end else begin
                case (fsm_q)
                    IDLE, DONE: begin
                        if (start) begin
                            fsm_q     <= RUN;
                            busy_q    <= 1'b1;
                            done_q    <= 1'b0;
                            steady_q  <= 1'b0;
                            state_q   <= init_state;
                            lfsr_q    <= (seed == 64'd0) ? 64'd1 : seed;
                            step_q    <= '0;
                            updated_q <= '0;
                            rr_q      <= '0;
                            limit_q   <= (max_steps == '0) ? '1 : max_steps;
                        end
                    end
                    RUN: begin
                        lfsr_q    <= lfsr_d;
                        state_q   <= state_d;
                        updated_q <= updated_d;
                        step_q    <= step_d;
                        if (mode == MODE_RR) begin
                            rr_q <= rr_d;
                        end
                        if (steady_hit || limit_hit) begin
                            fsm_q    <= DONE;
                            busy_q   <= 1'b0;
                            done_q   <= 1'b1;
                            steady_q <= steady_hit;
                        end
                    end
                    default: begin
                        fsm_q  <= IDLE;
                        busy_q <= 1'b0;
                        done_q <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ra_sim_engine.sv
`default_nettype none
// ============================================================================
// tb_ra_sim_engine : vector table + scoreboard bench for ra_sim_engine
// Revision         : 1.0
// ============================================================================
module tb_ra_sim_engine;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // Instance A: RULES=4, LOG_RULES=2
    logic        start_a, abort_a, ld_a, clr_a;
    logic [1:0]  mode_a, sel_a, kind_a;
    logic [63:0] seed_a;
    logic [3:0]  init_a, pat_a, lo_a, ns_a;
    logic [15:0] max_a, step_a;
    logic        busy_a, done_a, steady_a;

    assign lo_a = (kind_a == 2'd0) ? ns_a : (kind_a == 2'd1) ? ~ns_a : pat_a;

    ra_sim_engine #(.RULES(4), .LOG_RULES(2), .STEP_W(16)) u_dut_a (
        .clk(clk), .rst(rst_n), .start(start_a), .abort(abort_a), .mode(mode_a),
        .seed(seed_a), .init_state(init_a), .max_steps(max_a),
        .ld_inhibitor(ld_a), .sel_inhibitor(sel_a), .clr_inhibitor(clr_a),
        .logic_output(lo_a), .network_state(ns_a), .busy(busy_a), .done(done_a),
        .steady_state(steady_a), .step_count(step_a)
    );

    // Instance B: RULES=5, LOG_RULES=3, identity network
    logic        start_b, abort_b, ld_b, clr_b;
    logic [1:0]  mode_b;
    logic [2:0]  sel_b;
    logic [63:0] seed_b;
    logic [4:0]  init_b, lo_b, ns_b;
    logic [15:0] max_b, step_b;
    logic        busy_b, done_b, steady_b;

    assign lo_b = ns_b;

    ra_sim_engine #(.RULES(5), .LOG_RULES(3), .STEP_W(16)) u_dut_b (
        .clk(clk), .rst(rst_n), .start(start_b), .abort(abort_b), .mode(mode_b),
        .seed(seed_b), .init_state(init_b), .max_steps(max_b),
        .ld_inhibitor(ld_b), .sel_inhibitor(sel_b), .clr_inhibitor(clr_b),
        .logic_output(lo_b), .network_state(ns_b), .busy(busy_b), .done(done_b),
        .steady_state(steady_b), .step_count(step_b)
    );

    typedef struct {
        logic [1:0]  mode;
        logic [3:0]  init;
        logic [1:0]  kind;
        logic [3:0]  pat;
        logic [15:0] maxs;
        logic [63:0] seed;
        logic        e_st;
        logic [15:0] e_steps;
        logic [3:0]  e_state;
        logic [3:0]  e_mask;
        int          e_cyc;
    } vec_t;

    typedef struct {
        logic        e_st;
        logic [15:0] e_steps;
        logic [3:0]  e_state;
        logic [3:0]  e_mask;
        int          e_cyc;
    } exp_t;

    exp_t sb[$];
    vec_t vec[10];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Random-async identity run: count valid steps and total RUN cycles until all bits visited
    function automatic int m0_model(input logic [63:0] sd, input int rules, input int logr,
                                    output int cyc);
        logic [63:0] s;
        int vis, st, idx;
        s   = (sd == 64'd0) ? 64'd1 : sd;
        vis = 0;
        st  = 0;
        cyc = 0;
        while (vis != ((1 << rules) - 1) && cyc < 4000) begin
            idx = int'(s[7:0]) & ((1 << logr) - 1);
            cyc++;
            if (idx < rules) begin
                st++;
                vis = vis | (1 << idx);
            end
            s = {s[62:0], s[63] ^ s[62] ^ s[60] ^ s[59]};
        end
        return st;
    endfunction

    task automatic drive_start(input vec_t v);
        exp_t e;
        @(negedge clk);
        mode_a = v.mode; init_a = v.init; kind_a = v.kind; pat_a = v.pat;
        max_a = v.maxs; seed_a = v.seed; start_a = 1'b1;
        e.e_st = v.e_st; e.e_steps = v.e_steps; e.e_state = v.e_state;
        e.e_mask = v.e_mask; e.e_cyc = v.e_cyc;
        sb.push_back(e);
        @(negedge clk);
        start_a = 1'b0;
    endtask

    task automatic wait_pop(input string nm);
        exp_t e;
        int cyc;
        cyc = 0;
        while (busy_a && cyc < 5000) begin
            cyc++;
            @(negedge clk);
        end
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s_queue: got empty expected entry", nm);
        end else begin
            e = sb.pop_front();
            chk({nm, "_done"}, done_a, 1'b1);
            chk({nm, "_steady"}, steady_a, e.e_st);
            chk({nm, "_steps"}, step_a, e.e_steps);
            if (e.e_mask != 4'h0) chk({nm, "_state"}, ns_a & e.e_mask, e.e_state & e.e_mask);
            if (e.e_cyc >= 0) chk({nm, "_cycles"}, cyc, e.e_cyc);
        end
    endtask

    initial begin
        int m, c, n;
        rst_n = 1'b0;
        start_a = 0; abort_a = 0; ld_a = 0; clr_a = 0; mode_a = 0; sel_a = 0; kind_a = 0;
        seed_a = 0; init_a = 0; pat_a = 0; max_a = 0;
        start_b = 0; abort_b = 0; ld_b = 0; clr_b = 0; mode_b = 0; sel_b = 0;
        seed_b = 0; init_b = 0; max_b = 0;

        vec[0] = '{2'd1, 4'b1010, 2'd0, 4'b0000, 16'd0,  64'd1, 1'b1, 16'd4,  4'b1010, 4'hF, 4};
        vec[1] = '{2'd0, 4'b0000, 2'd1, 4'b0000, 16'd20, 64'd1, 1'b0, 16'd20, 4'b0000, 4'h0, 20};
        vec[2] = '{2'd1, 4'b0000, 2'd1, 4'b0000, 16'd7,  64'd1, 1'b0, 16'd7,  4'b1000, 4'hF, 7};
        vec[3] = '{2'd1, 4'b0000, 2'd2, 4'b0110, 16'd0,  64'd1, 1'b1, 16'd6,  4'b0110, 4'hF, 6};
        vec[4] = '{2'd1, 4'b1010, 2'd0, 4'b0000, 16'd3,  64'd1, 1'b0, 16'd3,  4'b1010, 4'hF, 3};
        vec[5] = '{2'd1, 4'b1010, 2'd0, 4'b0000, 16'd4,  64'd1, 1'b1, 16'd4,  4'b1010, 4'hF, 4};
        m = m0_model(64'd1, 4, 2, c);
        vec[6] = '{2'd0, 4'b0101, 2'd0, 4'b0000, 16'd0, 64'd1, 1'b1, 16'(m), 4'b0101, 4'hF, c};
        m = m0_model(64'hDEADBEEF_CAFEF00D, 4, 2, c);
        vec[7] = '{2'd3, 4'b0011, 2'd0, 4'b0000, 16'd0, 64'hDEADBEEF_CAFEF00D, 1'b1, 16'(m),
                   4'b0011, 4'hF, c};
        m = m0_model(64'd0, 4, 2, c);
        vec[8] = '{2'd0, 4'b1001, 2'd0, 4'b0000, 16'd0, 64'd0, 1'b1, 16'(m), 4'b1001, 4'hF, c};
`ifdef RA_SYNC_MODE_EN
        m = 1; c = 1;
`else
        m = m0_model(64'h5, 4, 2, c);
`endif
        vec[9] = '{2'd2, 4'b0110, 2'd0, 4'b0000, 16'd0, 64'h5, 1'b1, 16'(m), 4'b0110, 4'hF, c};

        repeat (3) @(negedge clk);
        chk("reset_a", {ns_a, busy_a, done_a, steady_a, step_a}, 64'd0);
        chk("reset_b", {ns_b, busy_b, done_b, steady_b, step_b}, 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_a", {ns_a, busy_a, done_a, steady_a, step_a}, 64'd0);

        for (int i = 0; i < 10; i++) begin
            drive_start(vec[i]);
            wait_pop($sformatf("vec%0d", i));
        end

        repeat (3) @(negedge clk);
        chk("done_held", done_a, 1'b1);
        chk("step_held", step_a, vec[9].e_steps);

        // Inhibit bit 1 in the same cycle as start, identity network, round-robin
        @(negedge clk);
        ld_a = 1; sel_a = 2'd1; mode_a = 2'd1; init_a = 4'hF; kind_a = 2'd0;
        max_a = 0; seed_a = 64'd1; start_a = 1;
        sb.push_back('{1'b1, 16'd4, 4'b1101, 4'hF, 4});
        @(negedge clk);
        ld_a = 0; start_a = 0;
        chk("inhib_mask", ns_a, 4'b1101);
        wait_pop("inhib_run");

        // Clear beats simultaneous load
        @(negedge clk);
        ld_a = 1; sel_a = 2'd2; clr_a = 1;
        @(negedge clk);
        ld_a = 0; clr_a = 0;
        chk("clr_wins", ns_a, 4'b1101);

        // Abort mid-run, with a simultaneous start
        @(negedge clk);
        mode_a = 2'd1; init_a = 4'b0000; kind_a = 2'd1; max_a = 0; start_a = 1;
        @(negedge clk);
        start_a = 0;
        repeat (2) @(negedge clk);
        abort_a = 1; start_a = 1;
        @(negedge clk);
        abort_a = 0; start_a = 0;
        chk("abort_busy", busy_a, 1'b0);
        chk("abort_done", done_a, 1'b0);
        chk("abort_step", step_a, 16'd2);
        @(negedge clk);
        chk("abort_idle", busy_a, 1'b0);

        // Asynchronous reset at step 7
        @(negedge clk);
        mode_a = 2'd1; init_a = 4'b0000; kind_a = 2'd1; max_a = 0; start_a = 1;
        @(negedge clk);
        start_a = 0;
        n = 0;
        while (step_a != 16'd7 && n < 100) begin
            n++;
            @(negedge clk);
        end
        chk("reach_step7", step_a, 16'd7);
        rst_n = 1'b0;
        #1;
        chk("rst_async", {ns_a, busy_a, done_a, steady_a, step_a}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        drive_start(vec[0]);
        wait_pop("after_rst");

        // RULES=5: indices 5..7 consume cycles but never count
        m = m0_model(64'd1, 5, 3, c);
        @(negedge clk);
        mode_b = 2'd0; init_b = 5'b10110; seed_b = 64'd1; max_b = 0; start_b = 1;
        @(negedge clk);
        start_b = 0;
        n = 0;
        while (busy_b && n < 5000) begin
            n++;
            @(negedge clk);
        end
        chk("b_done", done_b, 1'b1);
        chk("b_steady", steady_b, 1'b1);
        chk("b_steps", step_b, 16'(m));
        chk("b_cycles", n, c);
        chk("b_state", ns_b, 5'b10110);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
